// File: rtl/button_debouncer_pkg.sv
// Shared constants for the button debouncer: register offsets and the
// default debounce interval.
package button_debouncer_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 240000;

  // Word offsets, decoded from address[3:2].
  typedef enum logic [1:0] {
    REG_STATE   = 2'd0,
    REG_PRESS   = 2'd1,
    REG_RELEASE = 2'd2,
    REG_IRQ_EN  = 2'd3
  } reg_addr_e;

endpackage

// File: rtl/button_debouncer_debounce_cell.sv
// One button: two-flop synchroniser, stability counter and debounced level.
// rise/fall pulse in the cycle whose edge commits a new stable level.
module debounce_cell
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] count;
  logic          accept;

  assign accept = (sync_q != stable) && (count == COUNT_MAX);
  assign rise   = accept && sync_q;
  assign fall   = accept && !sync_q;

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      count     <= '0;
      stable    <= 1'b0;
    end else begin
      sync_meta <= button;
      sync_q    <= sync_meta;
      if (sync_q == stable) begin
        count <= '0;
      end else if (accept) begin
        stable <= sync_q;
        count  <= '0;
      end else begin
        // accept catches COUNT_MAX, so this increment never wraps.
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounced button peripheral: per-button debounce cells plus a small
// register file (STATE, sticky PRESS/RELEASE, IRQ_EN) and a level irq.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned BUTTONCOUNT     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUTTONCOUNT-1:0] buttons,
  input  logic                   sel,
  input  logic [3:0]             address,
  input  logic [3:0]             write_mask,
  input  logic [31:0]            write_value,
  output logic [31:0]            read_value,
  output logic                   ready,
  output logic [BUTTONCOUNT-1:0] stable,
  output logic                   irq
);

  logic [BUTTONCOUNT-1:0] rise;
  logic [BUTTONCOUNT-1:0] fall;
  logic [BUTTONCOUNT-1:0] press_q;
  logic [BUTTONCOUNT-1:0] release_q;
  logic [BUTTONCOUNT-1:0] irq_en_q;
  logic [BUTTONCOUNT-1:0] press_clr;
  logic [BUTTONCOUNT-1:0] release_clr;
  logic [31:0]            read_next;
  logic                   access;
  logic                   wr;
  reg_addr_e              reg_sel;

  for (genvar i = 0; i < BUTTONCOUNT; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .button(buttons[i]),
      .stable(stable[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // A new access is accepted only while ready is low, giving the one-cycle
  // gap between back-to-back acknowledges.
  assign access  = sel && !ready;
  assign wr      = access && (write_mask != 4'h0);
  assign reg_sel = reg_addr_e'(address[3:2]);

  // Byte-offset bits and write data above the button field carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{address[1:0], write_value};

  // NOTE: defaults first so every path assigns and no latch is inferred.
  always_comb begin
    read_next   = '0;
    press_clr   = '0;
    release_clr = '0;
    unique case (reg_sel)
      REG_STATE:   read_next[BUTTONCOUNT-1:0] = stable;
      REG_PRESS:   read_next[BUTTONCOUNT-1:0] = press_q;
      REG_RELEASE: read_next[BUTTONCOUNT-1:0] = release_q;
      REG_IRQ_EN:  read_next[BUTTONCOUNT-1:0] = irq_en_q;
    endcase
    if (wr && reg_sel == REG_PRESS)   press_clr   = write_value[BUTTONCOUNT-1:0];
    if (wr && reg_sel == REG_RELEASE) release_clr = write_value[BUTTONCOUNT-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready      <= 1'b0;
      read_value <= '0;
      press_q    <= '0;
      release_q  <= '0;
      irq_en_q   <= '0;
      irq        <= 1'b0;
    end else begin
      ready      <= access;
      read_value <= access ? read_next : '0;
      // Event OR-ed in after the clear so a coincident set wins.
      press_q    <= (press_q & ~press_clr) | rise;
      release_q  <= (release_q & ~release_clr) | fall;
      if (wr && reg_sel == REG_IRQ_EN) irq_en_q <= write_value[BUTTONCOUNT-1:0];
      irq        <= |((press_q | release_q) & irq_en_q);
    end
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter BUTTONCOUNT, default 4: number of button inputs, range 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 240000: consecutive stable clk cycles required to accept a level change, minimum 2.
REQ-003 clk  input  1  system clock (PLL clock domain).
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 buttons  input  BUTTONCOUNT  raw asynchronous button levels from the pins, 1 = pressed.
REQ-006 sel  input  1  bus select for this peripheral.
REQ-007 address  input  4  byte address; only bits [3:2] are decoded.
REQ-008 write_mask  input  4  byte write enables; any nonzero value with sel set is a write.
REQ-009 write_value  input  32  write data.
REQ-010 read_value  output  32  read data, zero when not ready.
REQ-011 ready  output  1  one-cycle bus acknowledge.
REQ-012 stable  output  BUTTONCOUNT  debounced button levels.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 Each button is synchronised by two flip-flops before debouncing; the raw-to-counter latency is 2 cycles.
REQ-015 Per button: a counter clears whenever the synchronised level equals stable; otherwise it increments, saturating at DEBOUNCE_CYCLES-1.
REQ-016 When the counter is at DEBOUNCE_CYCLES-1 and the synchronised level still differs, stable takes the new level on the next edge and the counter clears.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes stable.
REQ-018 A 0->1 stable transition sets PRESS[i]; a 1->0 transition sets RELEASE[i]; both are sticky.
REQ-019 Register map (address[3:2]): 0 STATE (RO, = stable); 1 PRESS (W1C); 2 RELEASE (W1C); 3 IRQ_EN (RW, bits [BUTTONCOUNT-1:0]).
REQ-020 W1C: write_value bit i = 1 clears bit i; all other bits are unchanged.
REQ-021 If a set event and a W1C clear hit the same bit in the same cycle, the set wins.
REQ-022 Writes to STATE are ignored. Unused upper bits read as 0.
REQ-023 Bus: when sel is high and ready is low, ready asserts on the next cycle with registered read_value. ready then deasserts for one cycle even if sel remains high.
REQ-024 A write takes effect on the same edge that registers ready.
REQ-025 irq = |((PRESS | RELEASE) & IRQ_EN), registered, with one cycle of latency from the event or clear.

Reset
REQ-026 On reset: sync FFs, counters, stable, PRESS, RELEASE, IRQ_EN, ready, read_value and irq are all 0.
REQ-027 Reset asserted mid-debounce discards the partial count. After release, a button held high is accepted after 2 + DEBOUNCE_CYCLES cycles and sets PRESS.
REQ-028 A bus access in the cycle reset is high is dropped; no ready is produced.

Structure
REQ-029 The register offsets and the DEBOUNCE_CYCLES default are constants in the shared defines package.
REQ-030 The per-button synchroniser, counter and stable flop are one sub-module, debounce_cell, instantiated BUTTONCOUNT times with a generate loop. The counter width is $clog2(DEBOUNCE_CYCLES).
REQ-031 The register file, bus handshake and irq logic live in button_debouncer.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-032 Hold buttons=4'b0001 for 8 cycles -> stable[0]=1 exactly 6 cycles after the input edge; PRESS reads 0x1; irq stays 0.
REQ-033 Pulse buttons[1] high for 3 cycles -> stable, PRESS and RELEASE are unchanged.
REQ-034 Set IRQ_EN=0xF, press then release button 2 -> PRESS=0x4, RELEASE=0x4, irq=1. Write 0x4 to PRESS -> irq stays 1. Write 0x4 to RELEASE -> irq=0 one cycle later.
REQ-035 A button 3 accept edge coincides with a W1C of 0x8 to PRESS -> PRESS[3] reads 1.
REQ-036 Assert reset at counter value 2 -> counters clear; with buttons held at 0x1, stable[0] rises 6 cycles after reset release.
REQ-037 Hold sel high for 6 cycles reading STATE -> ready pattern 0,1,0,1,0,1, and read_value is 0 whenever ready=0.
